fft8_scheduler: RTL and testbench
=================================

FFT8_SCHEDULER -- requirements
Module: fft8_scheduler

Interface
REQ-001 Parameters: none; the block is fixed to an 8-point radix-2 DIT FFT with 3-bit sample addresses and 2-bit twiddle indices (W8^k, k=0..3).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request a new transform; sampled only in IDLE.
REQ-005 in_valid  in  1  input sample present this cycle.
REQ-006 in_ready  out  1  high in LOAD only; a sample is accepted when in_valid && in_ready.
REQ-007 ld_we  out  1  sample-bank write strobe, equal to in_valid && in_ready.
REQ-008 ld_addr  out  3  bit-reversed load address for the sample being accepted.
REQ-009 issue  out  1  a butterfly operand pair is presented this cycle.
REQ-010 rd_addr0 / rd_addr1  out  3 each  bank addresses feeding the butterfly's in0 and in1 ports.
REQ-011 tw_idx  out  2  twiddle index k selecting w_r/w_i = W8^k.
REQ-012 stage  out  2  current stage 0..2; 0 outside RUN.
REQ-013 wr_en  out  1  write butterfly outputs back in place.
REQ-014 wr_addr0 / wr_addr1  out  3 each  in-place destinations for out0 and out1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states are IDLE, LOAD, RUN, BUBBLE, DRAIN and DONE.
REQ-018 FSM transitions:
- IDLE->LOAD on start.
- LOAD->RUN on the 8th accepted sample.
- RUN->BUBBLE after butterfly 3 of stage 0 or stage 1.
- BUBBLE->RUN, advancing the stage.
- RUN->DRAIN after butterfly 3 of stage 2.
- DRAIN->DONE.
- DONE->IDLE.
REQ-019 In LOAD, a 3-bit counter n counts accepted samples, and ld_addr = {n[0],n[1],n[2]}; the counter holds while in_valid is 0, and there is no timeout.
REQ-020 In RUN, issue=1 every cycle; butterfly counter b (0..3) increments each cycle and wraps to 0 at a stage end.
REQ-021 Addressing for stage s, butterfly b:
- pos = b mod 2^s, grp = b >> s.
- rd_addr0 = grp*2^(s+1) + pos, rd_addr1 = rd_addr0 + 2^s.
- tw_idx = pos * 2^(2-s); all values are unsigned and exact within their widths.
REQ-022 Required issue order and pairs:
- s0: (0,1)k0 (2,3)k0 (4,5)k0 (6,7)k0.
- s1: (0,2)k0 (1,3)k2 (4,6)k0 (5,7)k2.
- s2: (0,4)k0 (1,5)k1 (2,6)k2 (3,7)k3.
REQ-023 Write-back latency is exactly 1 cycle: wr_en, wr_addr0 and wr_addr1 are the registered values of issue, rd_addr0 and rd_addr1.
REQ-024 The BUBBLE cycle has issue=0; the last write of a stage lands during BUBBLE, so no stage reads an address before its prior-stage write completes.
REQ-025 DRAIN has issue=0 and wr_en=1, carrying the final write of (3,7).
REQ-026 Cycle timing relative to R0, the first RUN cycle (the cycle after the 8th accept):
- Issues occur at R0-R3, R5-R8 and R10-R13.
- Bubbles occur at R4 and R9; DRAIN is R14.
- done=1 at R15 only; busy=0 and the FSM is in IDLE from R16.
REQ-027 While busy=1, start is ignored and no restart or queuing occurs.
REQ-028 in_valid outside LOAD is ignored: ld_we=0 and in_ready=0.
REQ-029 While issue=0, rd_addr0, rd_addr1 and tw_idx are driven to 0.
REQ-030 start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.

Reset
REQ-031 When RST=0 at a rising edge, the FSM enters IDLE and all counters clear, regardless of the current state, including mid-LOAD or mid-RUN.
REQ-032 While in reset, all outputs are 0, and any pending write-back register is cleared, so there is no wr_en after reset.
REQ-033 Outputs are valid from the first edge with RST=1; start is accepted in that cycle.

Verification
REQ-034 Load order: start, then in_valid continuously for 8 cycles -> ld_addr sequence is 0,4,2,6,1,5,3,7, and in_ready drops after the 8th accept.
REQ-035 Full schedule: check rd_addr0, rd_addr1 and tw_idx against REQ-022 at R0-R13, issue=0 at R4/R9, wr_addr always equal to the previous cycle's rd_addr, and done only at R15.
REQ-036 Gapped load: in_valid pattern 1,0,0,1,... -> only accepts advance n, and R0 falls exactly one cycle after the 8th accept.
REQ-037 Ignored inputs: start pulsed at R2 and in_valid=1 throughout RUN -> no schedule change and ld_we stays 0.
REQ-038 Reset mid-run: RST=0 at R6 -> next cycle all outputs are 0 with wr_en=0; a new start then gives a full correct transform.
REQ-039 Golden end-to-end: butterfly plus an 8x(real,imag) bank, input x=[1,0,0,0,0,0,0,0] (Q8.8 0x0100) -> all 8 outputs are 0x0100 real and 0 imaginary; input all-ones -> X[0]=0x0800 and X[1..7]=0.

Source files
------------

// File: rtl/fft8_scheduler.sv
// Address and control sequencer for an in-place 8-point radix-2 DIT FFT:
// bit-reversed sample load, three butterfly stages with a bubble between them, 1-cycle write-back.
module fft8_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ld_we,
    output logic [2:0] ld_addr,
    output logic       issue,
    output logic [2:0] rd_addr0,
    output logic [2:0] rd_addr1,
    output logic [1:0] tw_idx,
    output logic [1:0] stage,
    output logic       wr_en,
    output logic [2:0] wr_addr0,
    output logic [2:0] wr_addr1,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_BUBBLE = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t     state;
    logic [2:0] n;
    logic [1:0] b;
    logic [1:0] s;

    // Handshake: a sample transfers on a cycle where in_valid && in_ready; in_ready depends only
    // on state, never on in_valid, and in_valid is free to drop at any time without timeout.
    assign in_ready  = (state == S_LOAD);
    assign ld_we     = in_valid && in_ready;
    assign ld_addr   = {n[0], n[1], n[2]};
    assign issue     = (state == S_RUN);
    assign stage     = issue ? s : 2'd0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // Stage s, butterfly b: pairs are 2^s apart, groups of 2^(s+1); twiddle step shrinks per stage.
    always_comb begin
        rd_addr0 = 3'd0;
        rd_addr1 = 3'd0;
        tw_idx   = 2'd0;
        if (issue) begin
            case (s)
                2'd0: begin
                    rd_addr0 = {b, 1'b0};
                    rd_addr1 = {b, 1'b1};
                end
                2'd1: begin
                    rd_addr0 = {b[1], 1'b0, b[0]};
                    rd_addr1 = {b[1], 1'b1, b[0]};
                    tw_idx   = {b[0], 1'b0};
                end
                default: begin
                    rd_addr0 = {1'b0, b};
                    rd_addr1 = {1'b1, b};
                    tw_idx   = b;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            n        <= 3'd0;
            b        <= 2'd0;
            s        <= 2'd0;
            wr_en    <= 1'b0;
            wr_addr0 <= 3'd0;
            wr_addr1 <= 3'd0;
        end else begin
            wr_en    <= issue;
            wr_addr0 <= rd_addr0;
            wr_addr1 <= rd_addr1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        n     <= 3'd0;
                    end
                end
                S_LOAD: begin
                    if (ld_we) begin
                        n <= n + 3'd1;
                        if (n == 3'd7) begin
                            state <= S_RUN;
                            b     <= 2'd0;
                            s     <= 2'd0;
                        end
                    end
                end
                S_RUN: begin
                    b <= b + 2'd1;
                    if (b == 2'd3) begin
                        state <= (s == 2'd2) ? S_DRAIN : S_BUBBLE;
                    end
                end
                // The previous stage's last write lands here, before the next stage reads.
                S_BUBBLE: begin
                    s     <= s + 2'd1;
                    state <= S_RUN;
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    s     <= 2'd0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_scheduler.sv
// Self-checking bench for fft8_scheduler: cycle-level reference model, issue/write scoreboard,
// and a Q8.8 butterfly plus sample bank driven by the scheduler's addresses for golden results.
module tb_fft8_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       ld_we;
    logic [2:0] ld_addr;
    logic       issue;
    logic [2:0] rd_addr0;
    logic [2:0] rd_addr1;
    logic [1:0] tw_idx;
    logic [1:0] stage;
    logic       wr_en;
    logic [2:0] wr_addr0;
    logic [2:0] wr_addr1;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    fft8_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .issue(issue), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_idx(tw_idx),
        .stage(stage), .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model state ----------------
    int m_mode = 0;        // 0 idle, 1 load, 2 transform in flight (R0..R15)
    int m_n = 0;           // samples accepted so far
    int m_rel = 0;         // cycles since R0
    int m_prev_issue = 0;
    int m_in_rst = 0;

    logic [9:0] exp_q[$];  // {stage, rd_addr0, rd_addr1, tw_idx} per expected issue
    logic [5:0] wr_q[$];   // {wr_addr0, wr_addr1} per expected write-back

    function automatic int bitrev3(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 3; i++)
            if (((v >> i) & 1) != 0) r += (1 << (2 - i));
        return r;
    endfunction

    task automatic push_schedule();
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                int pos, grp, a0, a1, tw;
                logic [9:0] e;
                pos = b % (1 << s);
                grp = b >> s;
                a0  = grp * (1 << (s + 1)) + pos;
                a1  = a0 + (1 << s);
                tw  = pos * (1 << (2 - s));
                e   = {2'(s), 3'(a0), 3'(a1), 2'(tw)};
                exp_q.push_back(e);
            end
        end
    endtask

    // ---------------- datapath emulation (Q8.8) ----------------
    int bank_re[8];
    int bank_im[8];
    int p0r, p0i, p1r, p1i;
    int smp_re, smp_im;
    int d_re[8];
    int d_im[8];

    function automatic int tw_re(input int k);
        case (k)
            0: return 256;
            1: return 181;
            2: return 0;
            default: return -181;
        endcase
    endfunction

    function automatic int tw_im(input int k);
        case (k)
            0: return 0;
            1: return -181;
            2: return -256;
            default: return -181;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        int e_issue, e_done, e_ldwe, all_out, tr, ti, ar, ai, br, bi, k;
        logic [9:0] e;
        logic [5:0] w;

        e_issue = (m_mode == 2 && m_rel <= 13 && (m_rel % 5) != 4) ? 1 : 0;
        e_done  = (m_mode == 2 && m_rel == 15) ? 1 : 0;
        e_ldwe  = (m_mode == 1 && in_valid) ? 1 : 0;

        if (m_in_rst != 0) begin
            all_out = int'({in_ready, ld_we, ld_addr, issue, rd_addr0, rd_addr1, tw_idx, stage,
                            wr_en, wr_addr0, wr_addr1, busy, done});
            chk("reset_outputs", all_out, 0);
        end else begin
            chk("in_ready", int'(in_ready), (m_mode == 1) ? 1 : 0);
            chk("ld_we", int'(ld_we), e_ldwe);
            if (e_ldwe != 0) chk("ld_addr", int'(ld_addr), bitrev3(m_n));
            chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
            chk("issue", int'(issue), e_issue);
            chk("done", int'(done), e_done);
            chk("wr_en", int'(wr_en), m_prev_issue);
            if (e_issue == 0) chk("idle_addr", int'({rd_addr0, rd_addr1, tw_idx, stage}), 0);
        end

        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                bound_fail("unexpected_write");
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", int'({wr_addr0, wr_addr1}), int'(w));
            end
        end
        if (issue === 1'b1) begin
            if (exp_q.size() == 0) begin
                bound_fail("unexpected_issue");
            end else begin
                e = exp_q.pop_front();
                chk("rd_pair", int'({stage, rd_addr0, rd_addr1, tw_idx}), int'(e));
                wr_q.push_back(e[7:2]);
            end
        end

        // Bank traffic: write-back lands before this cycle's read
        if (wr_en === 1'b1) begin
            bank_re[wr_addr0] = p0r; bank_im[wr_addr0] = p0i;
            bank_re[wr_addr1] = p1r; bank_im[wr_addr1] = p1i;
        end
        if (ld_we === 1'b1) begin
            bank_re[ld_addr] = smp_re; bank_im[ld_addr] = smp_im;
        end
        if (issue === 1'b1) begin
            k  = int'(tw_idx);
            ar = bank_re[rd_addr0]; ai = bank_im[rd_addr0];
            br = bank_re[rd_addr1]; bi = bank_im[rd_addr1];
            tr = (tw_re(k) * br - tw_im(k) * bi) >>> 8;
            ti = (tw_re(k) * bi + tw_im(k) * br) >>> 8;
            p0r = ar + tr; p0i = ai + ti;
            p1r = ar - tr; p1i = ai - ti;
        end

        // Advance the model to the next cycle
        if (!rst) begin
            m_mode = 0; m_n = 0; m_rel = 0; m_prev_issue = 0; m_in_rst = 1;
            exp_q.delete();
            wr_q.delete();
        end else begin
            m_in_rst = 0;
            m_prev_issue = e_issue;
            case (m_mode)
                0: if (start) begin m_mode = 1; m_n = 0; end
                1: if (in_valid) begin
                       m_n++;
                       if (m_n == 8) begin
                           m_mode = 2;
                           m_rel = 0;
                           push_schedule();
                       end
                   end
                default: begin
                    m_rel++;
                    if (m_rel == 16) m_mode = 0;
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    // gap_mode: 0 continuous, 1 pattern 1,0,0 repeating, 2 random
    task automatic load_samples(input int gap_mode);
        int acc, i, v;
        acc = 0;
        i = 0;
        while (acc < 8 && i < 200) begin
            case (gap_mode)
                0: v = 1;
                1: v = ((i % 3) == 0) ? 1 : 0;
                default: v = int'($urandom_range(0, 1));
            endcase
            in_valid = (v != 0);
            smp_re = d_re[acc];
            smp_im = d_im[acc];
            if (v != 0 && in_ready) acc++;
            tick();
            i++;
        end
        in_valid = 1'b0;
        if (acc < 8) bound_fail("load_timeout");
    endtask

    task automatic wait_done(input bit hold_valid, input bit pulse_r2);
        int r;
        bit got;
        r = 0;
        got = 0;
        in_valid = hold_valid;
        while (r < 40 && !got) begin
            start = (pulse_r2 && r == 2);
            if (done) got = 1;
            else begin
                tick();
                r++;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!got) bound_fail("done_timeout");
    endtask

    task automatic run_xform(input int gap_mode, input bit hold_valid, input bit pulse_r2);
        start = 1'b1;
        tick();
        start = 1'b0;
        load_samples(gap_mode);
        wait_done(hold_valid, pulse_r2);
    endtask

    task automatic set_impulse();
        for (int k = 0; k < 8; k++) begin
            d_re[k] = (k == 0) ? 256 : 0;
            d_im[k] = 0;
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < 8; k++) begin
            d_re[k] = int'($urandom_range(0, 511)) - 256;
            d_im[k] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    task automatic check_impulse_result();
        for (int k = 0; k < 8; k++) begin
            chk("impulse_re", bank_re[k], 256);
            chk("impulse_im", bank_im[k], 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        smp_re = 0; smp_im = 0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Impulse, back-to-back load
        set_impulse();
        run_xform(0, 1'b0, 1'b0);
        check_impulse_result();
        repeat (2) tick();

        // All-ones, gapped 1,0,0 load
        for (int k = 0; k < 8; k++) begin
            d_re[k] = 256;
            d_im[k] = 0;
        end
        run_xform(1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("ones_re", bank_re[k], (k == 0) ? 2048 : 0);
            chk("ones_im", bank_im[k], 0);
        end
        repeat (2) tick();

        // Random data, in_valid held through the run and start pulsed at R2
        set_random();
        run_xform(2, 1'b1, 1'b1);

        // start held over the DONE cycle: only the following IDLE cycle counts
        start = 1'b1;
        tick();
        set_random();
        run_xform(2, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset at R6, then start in the first cycle out of reset
        set_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        load_samples(2);
        repeat (6) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_impulse();
        run_xform(0, 1'b0, 1'b0);
        check_impulse_result();

        for (int t = 0; t < 3; t++) begin
            repeat (int'($urandom_range(1, 3))) tick();
            set_random();
            run_xform(2, ($urandom_range(0, 1) == 1), 1'b0);
        end

        repeat (4) tick();
        chk("issue_queue_empty", exp_q.size(), 0);
        chk("write_queue_empty", wr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
